// File: rtl/id_ex_issue.sv
// RV32I decode/issue stage: register read, operand select and ALU op mapping
// into a one-entry registered payload toward EX, with backpressure and flush.
package id_ex_pkg;
    typedef enum logic [3:0] {
        ALU_NONE, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B, ALU_SEQ, ALU_SNE,
        ALU_SGE, ALU_SGEU
    } ex_func;
endpackage

module id_ex_issue
    import id_ex_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic [4:0]      rf_rs1_addr,
    output logic [4:0]      rf_rs2_addr,
    input  logic [XLEN-1:0] rf_rs1_data,
    input  logic [XLEN-1:0] rf_rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            ex_ready,
    output ex_func          out_op,
    output logic [XLEN-1:0] out_operand_a,
    output logic [XLEN-1:0] out_operand_b,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_is_branch,
    output logic [31:0]     out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic is_op, is_opi, is_lui, is_auipc, is_jal, is_jalr;
    logic is_br, is_ld, is_st, f7_bad;

    assign opcode = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];
    assign rd = in_instr[11:7];
    assign rf_rs1_addr = in_instr[19:15];
    assign rf_rs2_addr = in_instr[24:20];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    assign is_op    = opcode == 7'b0110011;
    assign is_opi   = opcode == 7'b0010011;
    assign is_lui   = opcode == 7'b0110111;
    assign is_auipc = opcode == 7'b0010111;
    assign is_jal   = opcode == 7'b1101111;
    assign is_jalr  = opcode == 7'b1100111;
    assign is_br    = opcode == 7'b1100011;
    assign is_ld    = opcode == 7'b0000011;
    assign is_st    = opcode == 7'b0100011;
    assign f7_bad   = (f7 != 7'b0000000) && (f7 != 7'b0100000);

    function automatic ex_func alu_map(input logic [2:0] fn, input logic alt);
        ex_func r;
        case (fn)
            3'b000:  r = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r = ALU_SLL;
            3'b010:  r = ALU_SLT;
            3'b011:  r = ALU_SLTU;
            3'b100:  r = ALU_XOR;
            3'b101:  r = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r = ALU_OR;
            default: r = ALU_AND;
        endcase
        return r;
    endfunction

    ex_func d_op;
    logic [XLEN-1:0] d_a, d_b, d_imm;
    logic d_we, d_br, d_ill;

    always_comb begin
        d_op  = ALU_NONE;
        d_a   = rf_rs1_data;
        d_b   = rf_rs2_data;
        d_imm = '0;
        d_we  = 1'b0;
        d_br  = 1'b0;
        d_ill = 1'b0;
        unique case (1'b1)
            is_op: begin
                d_op = alu_map(f3, f7[5]);
                d_we = 1'b1;
                d_ill = f7_bad || (f7[5] && f3 != 3'b000 && f3 != 3'b101);
            end
            is_opi: begin
                d_imm = imm_i;
                d_b = imm_i;
                d_op = alu_map(f3, f3 == 3'b101 && f7[5]);
                d_we = 1'b1;
                // shifts take only the low five immediate bits
                if (f3 == 3'b001 || f3 == 3'b101)
                    d_b = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                if (f3 == 3'b001 && f7 != 7'b0000000) d_ill = 1'b1;
                if (f3 == 3'b101 && f7_bad) d_ill = 1'b1;
            end
            is_lui: begin
                d_op = ALU_PASS_B;
                d_b = imm_u;
                d_imm = imm_u;
                d_we = 1'b1;
            end
            is_auipc: begin
                d_op = ALU_ADD;
                d_a = in_pc;
                d_b = imm_u;
                d_imm = imm_u;
                d_we = 1'b1;
            end
            is_jal, is_jalr: begin
                d_op = ALU_ADD;
                d_a = in_pc;
                d_b = 32'd4;
                d_imm = is_jal ? imm_j : imm_i;
                d_we = 1'b1;
            end
            is_br: begin
                d_imm = imm_b;
                d_br = 1'b1;
                case (f3)
                    3'b000:  d_op = ALU_SEQ;
                    3'b001:  d_op = ALU_SNE;
                    3'b100:  d_op = ALU_SLT;
                    3'b101:  d_op = ALU_SGE;
                    3'b110:  d_op = ALU_SLTU;
                    3'b111:  d_op = ALU_SGEU;
                    default: d_ill = 1'b1;
                endcase
            end
            is_ld: begin
                d_op = ALU_ADD;
                d_b = imm_i;
                d_imm = imm_i;
                d_we = 1'b1;
            end
            is_st: begin
                d_op = ALU_ADD;
                d_b = imm_s;
                d_imm = imm_s;
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_op = ALU_NONE;
            d_we = 1'b0;
        end
        if (rd == 5'd0) d_we = 1'b0;
    end

    logic accept;
    assign in_ready = !out_valid || ex_ready;
    assign accept = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_op        <= ALU_NONE;
            out_operand_a <= '0;
            out_operand_b <= '0;
            out_imm       <= '0;
            out_rd        <= 5'd0;
            out_rd_we     <= 1'b0;
            out_is_branch <= 1'b0;
            out_illegal   <= 1'b0;
            out_pc        <= RESET_PC;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_op        <= d_op;
            out_operand_a <= d_a;
            out_operand_b <= d_b;
            out_imm       <= d_imm;
            out_rd        <= rd;
            out_rd_we     <= d_we;
            out_is_branch <= d_br;
            out_illegal   <= d_ill;
            out_pc        <= in_pc;
        end else if (ex_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue: decode map, handshake, flush,
// illegal encodings and asynchronous reset.
module tb_id_ex_issue;
    import id_ex_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0080;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, flush, out_valid, ex_ready;
    logic [31:0] in_instr, in_pc, rf_rs1_data, rf_rs2_data;
    logic [4:0] rf_rs1_addr, rf_rs2_addr, out_rd;
    ex_func out_op;
    logic [31:0] out_operand_a, out_operand_b, out_pc, out_imm;
    logic out_rd_we, out_is_branch, out_illegal;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_issue #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .flush(flush), .out_valid(out_valid), .ex_ready(ex_ready),
        .out_op(out_op), .out_operand_a(out_operand_a),
        .out_operand_b(out_operand_b), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_is_branch(out_is_branch),
        .out_pc(out_pc), .out_imm(out_imm), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc = pc;
        rf_rs1_data = r1;
        rf_rs2_data = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        in_pc = '0;
        rf_rs1_data = '0;
        rf_rs2_data = '0;
        flush = 1'b0;
        ex_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_op", 32'(out_op), 32'(ALU_NONE));
        chk("rst_pc", out_pc, RPC);
        chk("rst_a", out_operand_a, 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        drive(32'h0051_0093, 32'h0, 32'd10, 32'd99);
        #1;
        chk("addi_rs1_addr", 32'(rf_rs1_addr), 2);
        tick();
        in_valid = 1'b0;
        chk("addi_valid", 32'(out_valid), 1);
        chk("addi_op", 32'(out_op), 32'(ALU_ADD));
        chk("addi_a", out_operand_a, 10);
        chk("addi_b", out_operand_b, 5);
        chk("addi_rd", 32'(out_rd), 1);
        chk("addi_we", 32'(out_rd_we), 1);

        drive(32'h4020_81B3, 32'h4, 32'd7, 32'd9);
        tick();
        chk("sub_op", 32'(out_op), 32'(ALU_SUB));
        chk("sub_a", out_operand_a, 7);
        chk("sub_b", out_operand_b, 9);
        chk("sub_rd", 32'(out_rd), 3);

        drive(32'h4030_D213, 32'h8, 32'h8000_0000, 32'd0);
        tick();
        chk("srai_op", 32'(out_op), 32'(ALU_SRA));
        chk("srai_b", out_operand_b, 3);
        chk("srai_a", out_operand_a, 32'h8000_0000);

        drive(32'h1234_52B7, 32'hC, 32'd1, 32'd2);
        tick();
        chk("lui_op", 32'(out_op), 32'(ALU_PASS_B));
        chk("lui_b", out_operand_b, 32'h1234_5000);
        chk("lui_rd", 32'(out_rd), 5);

        drive(32'h0080_00EF, 32'h500, 32'd1, 32'd2);
        tick();
        chk("jal_op", 32'(out_op), 32'(ALU_ADD));
        chk("jal_a", out_operand_a, 32'h500);
        chk("jal_b", out_operand_b, 4);
        chk("jal_imm", out_imm, 8);

        drive(32'hFE20_9CE3, 32'h100, 32'd1, 32'd2);
        tick();
        chk("bne_op", 32'(out_op), 32'(ALU_SNE));
        chk("bne_br", 32'(out_is_branch), 1);
        chk("bne_imm", out_imm, 32'hFFFF_FFF8);
        chk("bne_we", 32'(out_rd_we), 0);
        chk("bne_pc", out_pc, 32'h100);

        ex_ready = 1'b0;
        drive(32'h0051_0093, 32'h200, 32'd33, 32'd0);
        #1;
        chk("bp_in_ready", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_op", 32'(out_op), 32'(ALU_SNE));
            chk("bp_hold_pc", out_pc, 32'h100);
            chk("bp_hold_valid", 32'(out_valid), 1);
        end
        ex_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 1);
        chk("bp_next_op", 32'(out_op), 32'(ALU_ADD));
        chk("bp_next_a", out_operand_a, 33);
        chk("bp_next_pc", out_pc, 32'h200);
        tick();
        chk("drain_valid", 32'(out_valid), 0);

        drive(32'h4020_81B3, 32'h240, 32'd7, 32'd9);
        tick();
        chk("pre_flush_valid", 32'(out_valid), 1);
        ex_ready = 1'b0;
        flush = 1'b1;
        drive(32'h1234_52B7, 32'h300, 32'd0, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 0);
        ex_ready = 1'b1;
        tick();
        chk("flush_no_ghost", 32'(out_valid), 0);

        drive(32'h0000_0000, 32'h400, 32'd1, 32'd2);
        tick();
        chk("ill0_valid", 32'(out_valid), 1);
        chk("ill0_flag", 32'(out_illegal), 1);
        chk("ill0_op", 32'(out_op), 32'(ALU_NONE));
        chk("ill0_we", 32'(out_rd_we), 0);

        drive(32'h0050_0013, 32'h404, 32'd0, 32'd0);
        tick();
        chk("addi_x0_we", 32'(out_rd_we), 0);
        chk("addi_x0_ill", 32'(out_illegal), 0);
        chk("addi_x0_op", 32'(out_op), 32'(ALU_ADD));

        drive(32'h0000_2063, 32'h408, 32'd0, 32'd0);
        tick();
        chk("br_f3_010_ill", 32'(out_illegal), 1);
        chk("br_f3_010_op", 32'(out_op), 32'(ALU_NONE));

        drive(32'h4010_9093, 32'h40C, 32'd0, 32'd0);
        tick();
        chk("slli_f7_ill", 32'(out_illegal), 1);
        chk("slli_f7_we", 32'(out_rd_we), 0);

        drive(32'h0051_0093, 32'h600, 32'd10, 32'd0);
        tick();
        in_valid = 1'b0;
        ex_ready = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_pc", out_pc, RPC);
        @(negedge clk);
        rst_n = 1'b1;
        ex_ready = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
